// File: rtl/add_operand_loader_if.sv
// Word-stream and operand-set handshake bundle for the wide-adder operand loader.
// The master side is the host/downstream environment; the slave side is the loader itself.
interface add_operand_loader_if #(
  parameter int unsigned OP_W   = 100,
  parameter int unsigned WORD_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic              in_cin;
  logic              out_valid;
  logic              out_ready;
  logic [OP_W-1:0]   out_a;
  logic [OP_W-1:0]   out_b;
  logic              out_cin;

  modport master (
    output in_valid, in_data, in_cin, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_cin
  );

  modport slave (
    input  in_valid, in_data, in_cin, out_ready,
    output in_ready, out_valid, out_a, out_b, out_cin
  );
endinterface

// File: rtl/add_operand_loader.sv
// Builds two OP_W-bit operands plus carry-in from a WORD_W-bit valid/ready word stream
// and holds them on registered outputs until the downstream adder stage accepts the set.
module add_operand_loader #(
  parameter int unsigned OP_W   = 100,
  parameter int unsigned WORD_W = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  add_operand_loader_if.slave bus
);
  localparam int unsigned BEATS  = (OP_W + WORD_W - 1) / WORD_W;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned PAD_W  = BEATS * WORD_W;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  localparam logic [1:0] ST_LOAD_A = 2'd0;
  localparam logic [1:0] ST_LOAD_B = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [OP_W-1:0]   a_q, a_d;
  logic [OP_W-1:0]   b_q, b_d;
  logic              cin_q, cin_d;

  logic              in_ready;
  logic              out_valid;
  logic              accept;
  logic              last_beat;
  logic [PAD_W-1:0]  a_ins;
  logic [PAD_W-1:0]  b_ins;

  // Ready/valid are pure state decodes so no in_* input reaches any output combinationally.
  assign in_ready  = (state_q != ST_HOLD);
  assign out_valid = (state_q == ST_HOLD);
  assign accept    = bus.in_valid && in_ready;
  assign last_beat = (beat_q == LAST_BEAT);

  // Padded copies absorb the bits of the final beat that lie above OP_W.
  always_comb begin
    a_ins = PAD_W'(a_q);
    b_ins = PAD_W'(b_q);
    a_ins[int'(beat_q) * WORD_W +: WORD_W] = bus.in_data;
    b_ins[int'(beat_q) * WORD_W +: WORD_W] = bus.in_data;
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;

    case (state_q)
      ST_LOAD_A: begin
        if (accept) begin
          a_d = a_ins[OP_W-1:0];
          if (last_beat) begin
            beat_d  = '0;
            state_d = ST_LOAD_B;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      ST_LOAD_B: begin
        if (accept) begin
          b_d = b_ins[OP_W-1:0];
          if (last_beat) begin
            beat_d  = '0;
            cin_d   = bus.in_cin;
            state_d = ST_HOLD;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      ST_HOLD: begin
        // Operand registers are deliberately kept after the handshake.
        if (bus.out_ready) begin
          beat_d  = '0;
          state_d = ST_LOAD_A;
        end
      end
      default: begin
        beat_d  = '0;
        state_d = ST_LOAD_A;
      end
    endcase

    if (clear) begin
      state_d = ST_LOAD_A;
      beat_d  = '0;
      a_d     = '0;
      b_d     = '0;
      cin_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_LOAD_A;
      beat_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_a     = a_q;
  assign bus.out_b     = b_q;
  assign bus.out_cin   = cin_q;

`ifndef SYNTHESIS
  hold_stable_a: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == ST_HOLD && !bus.out_ready && !clear)
      |=> (state_q == ST_HOLD && $stable(a_q) && $stable(b_q) && $stable(cin_q)));

  beat_in_range_a: assert property (@(posedge clk) disable iff (!rst_n)
    beat_q <= LAST_BEAT);

  hold_beat_zero_a: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == ST_HOLD) |-> (beat_q == '0));
`endif
endmodule

// File: tb/tb_add_operand_loader.sv
// Scoreboard bench for add_operand_loader: expected operand sets are queued as words are
// driven and compared when the loader presents them.
module tb_add_operand_loader;
  localparam int unsigned OP_W   = 100;
  localparam int unsigned WORD_W = 32;

  typedef struct packed {
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
    logic            cin;
  } exp_t;

  logic clk;
  logic rst_n;
  logic clear;
  int   n_checks;
  int   n_fail;
  int   cyc;
  exp_t sb[$];

  add_operand_loader_if #(.OP_W(OP_W), .WORD_W(WORD_W)) bus ();

  add_operand_loader #(.OP_W(OP_W), .WORD_W(WORD_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drives one word after 'gap' bubble cycles and waits (bounded) until it is accepted.
  task automatic drive_beat(input logic [31:0] d, input logic c, input int gap);
    bit done;
    repeat (gap) begin
      bus.in_valid = 1'b0;
      bus.in_data  = 32'hBAD0BAD0;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_cin   = c;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      done = bus.in_ready;
      @(posedge clk); #1;
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL beat_accept: in_ready never seen 1 (got 0, required 1)");
    end
    bus.in_valid = 1'b0;
    bus.in_cin   = 1'b0;
  endtask

  task automatic load_set(input logic [127:0] aw, input logic [127:0] bw, input logic c,
                          input int gap);
    exp_t e;
    e.a   = aw[OP_W-1:0];
    e.b   = bw[OP_W-1:0];
    e.cin = c;
    sb.push_back(e);
    for (int k = 0; k < 4; k++) drive_beat(aw[k*32 +: 32], ~c, gap);
    for (int k = 0; k < 4; k++) drive_beat(bw[k*32 +: 32], (k == 3) ? c : ~c, gap);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_cin    = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b required 1", bus.in_ready);
    end
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid: got %b required 0", bus.out_valid);
    end
    n_checks++;
    if (bus.out_a !== '0 || bus.out_b !== '0 || bus.out_cin !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_operands: got a=%h b=%h cin=%b required zeros",
               bus.out_a, bus.out_b, bus.out_cin);
    end
  endtask

  task automatic test_full_set();
    exp_t e;
    load_set({4{32'hFFFFFFFF}}, 128'h1, 1'b1, 0);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_valid: got valid=%b ready=%b required valid=1 ready=0",
               bus.out_valid, bus.in_ready);
    end
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++; $display("FAIL full_sb: got empty scoreboard required 1 entry");
    end else begin
      e = sb.pop_front();
      if (bus.out_a !== e.a || bus.out_b !== e.b || bus.out_cin !== e.cin) begin
        n_fail++;
        $display("FAIL full_data: got a=%h b=%h cin=%b required a=%h b=%h cin=%b",
                 bus.out_a, bus.out_b, bus.out_cin, e.a, e.b, e.cin);
      end
    end
    n_checks++;
    if (bus.out_a !== {OP_W{1'b1}}) begin
      n_fail++; $display("FAIL full_a_ones: got %h required all ones", bus.out_a);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL full_release: got valid=%b ready=%b required valid=0 ready=1",
               bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    logic [127:0] aw, bw;
    aw = {$urandom, $urandom, $urandom, $urandom};
    bw = {$urandom, $urandom, $urandom, $urandom};
    load_set(aw, bw, 1'b0, 0);
    e = sb.pop_front();
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_a !== e.a ||
          bus.out_b !== e.b || bus.out_cin !== e.cin) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got v=%b r=%b a=%h b=%h c=%b required v=1 r=0 a=%h b=%h c=%b",
                 i, bus.out_valid, bus.in_ready, bus.out_a, bus.out_b, bus.out_cin,
                 e.a, e.b, e.cin);
      end
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: got valid=%b ready=%b required valid=0 ready=1",
               bus.out_valid, bus.in_ready);
    end
    n_checks++;
    if (bus.out_a !== e.a || bus.out_b !== e.b) begin
      n_fail++;
      $display("FAIL bp_kept: got a=%h b=%h required a=%h b=%h", bus.out_a, bus.out_b, e.a, e.b);
    end
  endtask

  task automatic test_bubbles();
    exp_t e;
    logic [127:0] aw, bw;
    aw = {28'h0, 100'h0123456789ABCDEF012345678};
    bw = {$urandom, $urandom, $urandom, $urandom};
    e.a = aw[OP_W-1:0];
    e.b = bw[OP_W-1:0];
    e.cin = 1'b1;
    sb.push_back(e);
    for (int k = 0; k < 4; k++) drive_beat(aw[k*32 +: 32], 1'b0, 2);
    for (int k = 0; k < 3; k++) drive_beat(bw[k*32 +: 32], 1'b0, 2);
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out_a !== e.a) begin
      n_fail++;
      $display("FAIL bub_mid: got valid=%b a=%h required valid=0 a=%h",
               bus.out_valid, bus.out_a, e.a);
    end
    drive_beat(bw[96 +: 32], 1'b1, 2);
    n_checks++;
    if (bus.out_valid !== 1'b1) begin
      n_fail++; $display("FAIL bub_latency: got valid=%b required 1", bus.out_valid);
    end
    e = sb.pop_front();
    n_checks++;
    if (bus.out_a !== e.a || bus.out_b !== e.b || bus.out_cin !== e.cin) begin
      n_fail++;
      $display("FAIL bub_data: got a=%h b=%h cin=%b required a=%h b=%h cin=%b",
               bus.out_a, bus.out_b, bus.out_cin, e.a, e.b, e.cin);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int t0;
    bus.out_ready = 1'b1;
    for (int s = 0; s < 2; s++) begin
      load_set({$urandom, $urandom, $urandom, $urandom},
               {$urandom, $urandom, $urandom, $urandom}, s[0], 0);
      e = sb.pop_front();
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_a !== e.a || bus.out_b !== e.b ||
          bus.out_cin !== e.cin) begin
        n_fail++;
        $display("FAIL b2b_set%0d: got v=%b a=%h b=%h c=%b required v=1 a=%h b=%h c=%b",
                 s, bus.out_valid, bus.out_a, bus.out_b, bus.out_cin, e.a, e.b, e.cin);
      end
      if (s == 1) begin
        n_checks++;
        if (cyc - t0 != 9) begin
          n_fail++; $display("FAIL b2b_period: got %0d cycles required 9", cyc - t0);
        end
      end
      t0 = cyc;
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_clear();
    exp_t e;
    logic [127:0] aw;
    aw = {$urandom, $urandom, $urandom, $urandom};
    for (int k = 0; k < 4; k++) drive_beat(aw[k*32 +: 32], 1'b0, 0);
    n_checks++;
    if (bus.out_a !== aw[OP_W-1:0]) begin
      n_fail++; $display("FAIL clr_a_visible: got %h required %h", bus.out_a, aw[OP_W-1:0]);
    end
    drive_beat(32'h11111111, 1'b0, 0);
    drive_beat(32'h22222222, 1'b0, 0);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hDEADBEEF;
    bus.in_cin   = 1'b1;
    clear        = 1'b1;
    @(posedge clk); #1;
    clear        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_cin   = 1'b0;
    n_checks++;
    if (bus.out_a !== '0 || bus.out_b !== '0 || bus.out_cin !== 1'b0 ||
        bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_zero: got a=%h b=%h c=%b v=%b r=%b required zeros v=0 r=1",
               bus.out_a, bus.out_b, bus.out_cin, bus.out_valid, bus.in_ready);
    end
    load_set({$urandom, $urandom, $urandom, $urandom},
             {$urandom, $urandom, $urandom, $urandom}, 1'b1, 0);
    e = sb.pop_front();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_a !== e.a || bus.out_b !== e.b ||
        bus.out_cin !== e.cin) begin
      n_fail++;
      $display("FAIL clr_next: got v=%b a=%h b=%h c=%b required v=1 a=%h b=%h c=%b",
               bus.out_valid, bus.out_a, bus.out_b, bus.out_cin, e.a, e.b, e.cin);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    exp_t e;
    load_set({$urandom, $urandom, $urandom, $urandom},
             {$urandom, $urandom, $urandom, $urandom}, 1'b1, 0);
    void'(sb.pop_front());
    n_checks++;
    if (bus.out_valid !== 1'b1) begin
      n_fail++; $display("FAIL ar_pre: got valid=%b required 1", bus.out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_a !== '0 ||
        bus.out_b !== '0 || bus.out_cin !== 1'b0) begin
      n_fail++;
      $display("FAIL ar_async: got v=%b r=%b a=%h b=%h c=%b required v=0 r=1 zeros",
               bus.out_valid, bus.in_ready, bus.out_a, bus.out_b, bus.out_cin);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    load_set({$urandom, $urandom, $urandom, $urandom},
             {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1);
    e = sb.pop_front();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_a !== e.a || bus.out_b !== e.b ||
        bus.out_cin !== e.cin) begin
      n_fail++;
      $display("FAIL ar_restart: got v=%b a=%h b=%h c=%b required v=1 a=%h b=%h c=%b",
               bus.out_valid, bus.out_a, bus.out_b, bus.out_cin, e.a, e.b, e.cin);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    test_reset();
    test_full_set();
    test_backpressure();
    test_bubbles();
    test_back_to_back();
    test_clear();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
